// File: rtl/uart_rx_frame.sv
// UART receiver with fractional baud tick, 2-FF synchroniser, 3-sample majority vote,
// parity/framing checks, break lock-out and a valid/ready output with overrun pulse.
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int BAUD_WIDTH = 11,
    parameter int BAUD_ADD   = 170
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_rx,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BRK   = 3'd5;

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    logic [BAUD_WIDTH-1:0] acc_q;
    logic [BAUD_WIDTH:0]   acc_sum;
    logic                  tick;
    logic [1:0]            sync_q;
    logic                  rx_s;

    logic [2:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic                  stop_q, stop_d;
    logic                  s7_q, s7_d, s8_q, s8_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  perr_q, perr_d, ferr_q, ferr_d;
    logic                  done_q, done_d;
    logic                  vote, dec, wrap, exp_par;

    logic [DATA_BITS-1:0]  data_q;
    logic                  valid_q, operr_q, oferr_q, ovr_q;

    // Tick is the carry out of the phase accumulator: 16 ticks per bit.
    assign acc_sum = {1'b0, acc_q} + (BAUD_WIDTH+1)'(BAUD_ADD);
    assign tick    = acc_sum[BAUD_WIDTH];
    assign rx_s    = sync_q[1];

    assign vote    = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
    assign dec     = (cnt_q == 4'd9);
    assign wrap    = (cnt_q == 4'd15);
    assign exp_par = (PARITY == 2) ? ~(^shift_q) : ^shift_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        s7_d    = s7_q;
        s8_d    = s8_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        if (tick) begin
            if (state_q == S_IDLE) begin
                cnt_d = 4'd0;
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = 4'd1;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end else if (state_q == S_BRK) begin
                cnt_d = 4'd0;
                if (rx_s) state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) s7_d = rx_s;
                if (cnt_q == 4'd8) s8_d = rx_s;
                case (state_q)
                    S_START: begin
                        if (dec && vote) begin
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                        end else if (wrap) begin
                            state_d = S_DATA;
                            idx_d   = 4'd0;
                        end
                    end
                    S_DATA: begin
                        if (dec) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                        if (wrap) begin
                            if (idx_q == LAST_BIT) begin
                                state_d = (PARITY != 0) ? S_PAR : S_STOP;
                                stop_d  = 1'b0;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                    end
                    S_PAR: begin
                        if (dec && (vote != exp_par)) perr_d = 1'b1;
                        if (wrap) begin
                            state_d = S_STOP;
                            stop_d  = 1'b0;
                        end
                    end
                    S_STOP: begin
                        if (dec) begin
                            if (!vote) ferr_d = 1'b1;
                            // Last stop bit: deliver now, skip the remaining half bit.
                            if (stop_q == LAST_STOP) begin
                                done_d  = 1'b1;
                                cnt_d   = 4'd0;
                                state_d = (ferr_q || !vote) ? S_BRK : S_IDLE;
                            end
                        end else if (wrap) begin
                            stop_d = ~stop_q;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            acc_q   <= '0;
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            s7_q    <= 1'b1;
            s8_q    <= 1'b1;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_sum[BAUD_WIDTH-1:0];
            sync_q  <= {sync_q[0], i_rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            s7_q    <= s7_d;
            s8_q    <= s8_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
        end
    end

    // A held frame is only replaced when it is being consumed in the same cycle.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            operr_q <= 1'b0;
            oferr_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done_q && (!valid_q || i_ready)) begin
                data_q  <= shift_q;
                operr_q <= perr_q;
                oferr_q <= ferr_q;
                valid_q <= 1'b1;
            end else begin
                if (done_q) ovr_q <= 1'b1;
                if (valid_q && i_ready) valid_q <= 1'b0;
            end
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = operr_q;
    assign o_frame_err  = oferr_q;
    assign o_overrun    = ovr_q;
    assign o_busy       = (state_q != S_IDLE);
endmodule
